// File: rtl/truth_table_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_capture_if
//  Description : Truth-table word stream (valid/ready) between the capture
//                engine and its consumer. One word carries the complete table
//                of one DUT output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_capture_if #(
    parameter int N_IN = 2
) ();
    localparam int c_TT_W = 1 << N_IN;

    logic              tt_valid;
    logic              tt_ready;
    logic [5:0]        tt_idx;
    logic [c_TT_W-1:0] tt_data;

    modport master (output tt_valid, output tt_idx, output tt_data, input  tt_ready);
    modport slave  (input  tt_valid, input  tt_idx, input  tt_data, output tt_ready);
endinterface
`default_nettype wire

// File: rtl/truth_table_capture.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_capture
//  Description : Sweeps every input pattern of a small combinational circuit,
//                samples all of its outputs, and streams one packed truth
//                table per output over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_capture #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 10,
    parameter int SETTLE = 0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   start,
    output logic [N_IN-1:0]       x_drive,
    input  wire  [N_OUT-1:0]      f_obs,
    output logic                  busy,
    output logic                  done,
    truth_table_capture_if.master tt
);

    localparam int c_TT_W  = 1 << N_IN;
    localparam int c_SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int c_W_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [N_IN-1:0]    c_K_LAST   = {N_IN{1'b1}};
    localparam logic [c_SET_W-1:0] c_SET_INIT = c_SET_W'(SETTLE);
    localparam logic [c_W_W-1:0]   c_W_LAST   = c_W_W'(N_OUT - 1);

    // S_FIN is the single done cycle; start is not honoured there.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_EMIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [N_IN-1:0]     r_k;
    logic [c_SET_W-1:0]  r_cnt;
    logic [c_W_W-1:0]    r_w;
    logic [N_IN-1:0]     r_x;
    logic                r_valid;
    logic [5:0]          r_idx;
    logic [c_TT_W-1:0]   r_data;
    logic [c_TT_W-1:0]   r_tt [N_OUT];

    state_t              w_state_nxt;
    logic [N_IN-1:0]     w_k_nxt;
    logic [c_SET_W-1:0]  w_cnt_nxt;
    logic [c_W_W-1:0]    w_w_nxt;
    logic [c_W_W-1:0]    w_w_inc;
    logic [N_IN-1:0]     w_x_nxt;
    logic                w_valid_nxt;
    logic [5:0]          w_idx_nxt;
    logic [c_TT_W-1:0]   w_data_nxt;
    logic [c_TT_W-1:0]   w_first_word;
    logic                w_sample;

    // Next-state and next-output logic for the sweep/emit sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_w_nxt      = r_w;
        w_w_inc      = r_w + 1'b1;
        w_x_nxt      = r_x;
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_sample     = 1'b0;
        // Word 0 is loaded on the same edge that stores the last pattern,
        // so that final bit is forwarded straight from f_obs.
        w_first_word           = r_tt[0];
        w_first_word[c_K_LAST] = f_obs[0];

        case (r_state)
            S_IDLE: begin
                w_x_nxt = '0;
                if (start) begin
                    w_state_nxt = S_SWEEP;
                    w_k_nxt     = '0;
                    w_cnt_nxt   = c_SET_INIT;
                end
            end
            S_SWEEP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (r_k == c_K_LAST) begin
                        w_state_nxt = S_EMIT;
                        w_x_nxt     = '0;
                        w_w_nxt     = '0;
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = '0;
                        w_data_nxt  = w_first_word;
                    end else begin
                        w_k_nxt   = r_k + 1'b1;
                        w_x_nxt   = r_k + 1'b1;
                        w_cnt_nxt = c_SET_INIT;
                    end
                end
            end
            S_EMIT: begin
                // r_valid is always high here, so ready alone marks a handshake.
                if (tt.tt_ready) begin
                    if (r_w == c_W_LAST) begin
                        w_state_nxt = S_FIN;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_w_nxt    = w_w_inc;
                        w_idx_nxt  = 6'(w_w_inc);
                        w_data_nxt = r_tt[w_w_inc];
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_w     <= '0;
            r_x     <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
            r_w     <= w_w_nxt;
            r_x     <= w_x_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Table storage: one column (pattern k) written per sample, contents not reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_sample) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_tt[j][r_k] <= f_obs[j];
            end
        end
    end

    assign x_drive     = r_x;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign tt.tt_valid = r_valid;
    assign tt.tt_idx   = r_idx;
    assign tt.tt_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_capture
//  Description : Scoreboard bench for truth_table_capture. Two instances:
//                A (2 in, 10 out, no settle) and B (3 in, 4 out, settle 2),
//                each driving a bench-side lookup-table circuit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_truth_table_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] idx);
        n_checks++;
        n_fail++;
        $display("FAIL %s: word idx %0d handed over with nothing expected", name, idx);
    endtask

    // ---------------- instance A ----------------
    logic       a_start, a_busy, a_done;
    logic [1:0] a_x;
    logic [9:0] a_f;
    logic [9:0] a_lut [4];
    truth_table_capture_if #(.N_IN(2)) a_if ();
    assign a_f = a_lut[a_x];

    truth_table_capture #(.N_IN(2), .N_OUT(10), .SETTLE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .x_drive(a_x), .f_obs(a_f),
        .busy(a_busy), .done(a_done), .tt(a_if)
    );

    // ---------------- instance B ----------------
    logic       b_start, b_busy, b_done;
    logic [2:0] b_x;
    logic [3:0] b_f;
    logic [3:0] b_lut [8];
    truth_table_capture_if #(.N_IN(3)) b_if ();
    assign b_f = b_lut[b_x];

    truth_table_capture #(.N_IN(3), .N_OUT(4), .SETTLE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .x_drive(b_x), .f_obs(b_f),
        .busy(b_busy), .done(b_done), .tt(b_if)
    );

    // ---------------- scoreboards ----------------
    int         a_qi [$];
    logic [7:0] a_qd [$];
    int         b_qi [$];
    logic [7:0] b_qd [$];
    int a_done_cnt = 0, a_done_exp = 0;
    int b_done_cnt = 0, b_done_exp = 0;

    // Golden circuit of instance A: bit j-1 is fj.
    function automatic logic [9:0] gold_lut(input int k);
        logic x0, x1;
        logic [9:0] f;
        x0 = k[0];
        x1 = k[1];
        f[0] = x0 | x1;
        f[1] = x0 | x1;
        f[2] = x1 | ~x0;
        f[3] = 1'b0;
        f[4] = x1 | ~x0;
        f[5] = x0 | ~x1;
        f[6] = ~(x0 & x1);
        f[7] = ~(x0 & x1);
        f[8] = x0 & x1;
        f[9] = ~x0 & ~x1;
        return f;
    endfunction

    // Published truth tables of the golden circuit, word per output.
    function automatic logic [3:0] gold_word(input int j);
        case (j)
            0: return 4'b1110;
            1: return 4'b1110;
            2: return 4'b1101;
            3: return 4'b0000;
            4: return 4'b1101;
            5: return 4'b1011;
            6: return 4'b0111;
            7: return 4'b0111;
            8: return 4'b1000;
            default: return 4'b0001;
        endcase
    endfunction

    // Monitor A: pops expected words on every handshake, checks hold and done.
    logic       a_pv = 1'b0, a_pr = 1'b0, a_pdone = 1'b0, a_prst = 1'b0;
    logic [5:0] a_pidx = '0;
    logic [3:0] a_pdata = '0;
    int         a_ei;
    logic [7:0] a_ed;
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_prst && a_pv && !a_pr) begin
                check("a_hold_valid", 32'(a_if.tt_valid), 32'd1);
                check("a_hold_idx", 32'(a_if.tt_idx), 32'(a_pidx));
                check("a_hold_data", 32'(a_if.tt_data), 32'(a_pdata));
            end
            if (a_if.tt_valid && a_if.tt_ready) begin
                if (a_qi.size() == 0) begin
                    report_unexpected("a_word", 32'(a_if.tt_idx));
                end else begin
                    a_ei = a_qi.pop_front();
                    a_ed = a_qd.pop_front();
                    check("a_idx", 32'(a_if.tt_idx), 32'(a_ei));
                    check("a_data", 32'(a_if.tt_data), 32'(a_ed));
                end
            end
            if (a_done) begin
                a_done_cnt++;
                check("a_done_all_words", 32'(a_qi.size()), 32'd0);
                check("a_done_one_cycle", 32'(a_pdone), 32'd0);
            end
        end
        a_prst  <= rst_n;
        a_pv    <= a_if.tt_valid;
        a_pr    <= a_if.tt_ready;
        a_pidx  <= a_if.tt_idx;
        a_pdata <= a_if.tt_data;
        a_pdone <= a_done;
    end

    // Monitor B: same role for the 3-input instance.
    logic       b_pv = 1'b0, b_pr = 1'b0, b_pdone = 1'b0, b_prst = 1'b0;
    logic [5:0] b_pidx = '0;
    logic [7:0] b_pdata = '0;
    int         b_ei;
    logic [7:0] b_ed;
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_prst && b_pv && !b_pr) begin
                check("b_hold_valid", 32'(b_if.tt_valid), 32'd1);
                check("b_hold_idx", 32'(b_if.tt_idx), 32'(b_pidx));
                check("b_hold_data", 32'(b_if.tt_data), 32'(b_pdata));
            end
            if (b_if.tt_valid && b_if.tt_ready) begin
                if (b_qi.size() == 0) begin
                    report_unexpected("b_word", 32'(b_if.tt_idx));
                end else begin
                    b_ei = b_qi.pop_front();
                    b_ed = b_qd.pop_front();
                    check("b_idx", 32'(b_if.tt_idx), 32'(b_ei));
                    check("b_data", 32'(b_if.tt_data), 32'(b_ed));
                end
            end
            if (b_done) begin
                b_done_cnt++;
                check("b_done_all_words", 32'(b_qi.size()), 32'd0);
                check("b_done_one_cycle", 32'(b_pdone), 32'd0);
            end
        end
        b_prst  <= rst_n;
        b_pv    <= b_if.tt_valid;
        b_pr    <= b_if.tt_ready;
        b_pidx  <= b_if.tt_idx;
        b_pdata <= b_if.tt_data;
        b_pdone <= b_done;
    end

    // mode 0: golden, ready high; 1: golden, ready low 3 cycles on idx 4; 2: random circuit/ready
    task automatic run_a(input int mode);
        logic [7:0] w;
        int cyc;
        int low;
        for (int k = 0; k < 4; k++) a_lut[k] = (mode < 2) ? gold_lut(k) : 10'($urandom);
        for (int j = 0; j < 10; j++) begin
            if (mode < 2) begin
                w = {4'b0, gold_word(j)};
            end else begin
                w = '0;
                for (int k = 0; k < 4; k++) w[k] = a_lut[k][j];
            end
            a_qi.push_back(j);
            a_qd.push_back(w);
        end
        a_done_exp++;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("a_sweep_x", 32'(a_x), 32'(k));
            check("a_sweep_busy", 32'(a_busy), 32'd1);
            @(posedge clk); #1 a_start = 1'($urandom_range(0, 1));
        end
        check("a_emit_first_valid", 32'(a_if.tt_valid), 32'd1);
        check("a_emit_x_zero", 32'(a_x), 32'd0);
        cyc = 0;
        low = 0;
        while (!a_done && cyc < 200) begin
            if (mode == 0) begin
                a_if.tt_ready = 1'b1;
            end else if (mode == 1) begin
                if (a_if.tt_idx == 6'd4 && low < 3) begin
                    a_if.tt_ready = 1'b0;
                    low++;
                    check("a_bp_idx4_data", 32'(a_if.tt_data), 32'b1101);
                end else begin
                    a_if.tt_ready = 1'b1;
                end
            end else begin
                a_if.tt_ready = ($urandom_range(0, 2) != 0);
            end
            a_start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        check("a_done_seen", 32'(a_done), 32'd1);
        if (mode == 0) check("a_emit_cycles", 32'(cyc), 32'd10);
        a_start       = 1'b1;
        a_if.tt_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1 a_start = 1'b0;
        check("a_after_busy", 32'(a_busy), 32'd0);
        check("a_after_valid", 32'(a_if.tt_valid), 32'd0);
        check("a_after_done", 32'(a_done), 32'd0);
    endtask

    // Random circuit with f1 = majority(x0,x1,x2), random ready.
    task automatic run_b();
        logic [7:0] w;
        int cyc;
        for (int k = 0; k < 8; k++) begin
            b_lut[k]    = 4'($urandom);
            b_lut[k][0] = (k[0] & k[1]) | (k[0] & k[2]) | (k[1] & k[2]);
        end
        b_qi.push_back(0);
        b_qd.push_back(8'b1110_1000);
        for (int j = 1; j < 4; j++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w[k] = b_lut[k][j];
            b_qi.push_back(j);
            b_qd.push_back(w);
        end
        b_done_exp++;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 3; s++) begin
                check("b_sweep_x", 32'(b_x), 32'(k));
                @(posedge clk); #1 b_start = 1'($urandom_range(0, 1));
            end
        end
        check("b_emit_first_valid", 32'(b_if.tt_valid), 32'd1);
        check("b_emit_x_zero", 32'(b_x), 32'd0);
        cyc = 0;
        while (!b_done && cyc < 200) begin
            b_if.tt_ready = ($urandom_range(0, 1) != 0);
            b_start       = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        check("b_done_seen", 32'(b_done), 32'd1);
        b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check("b_after_busy", 32'(b_busy), 32'd0);
        check("b_after_done", 32'(b_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        a_start       = 1'b0;
        b_start       = 1'b0;
        a_if.tt_ready = 1'b0;
        b_if.tt_ready = 1'b0;
        for (int k = 0; k < 4; k++) a_lut[k] = gold_lut(k);
        for (int k = 0; k < 8; k++) b_lut[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_x", 32'(a_x), 32'd0);
        check("rst_a_valid", 32'(a_if.tt_valid), 32'd0);
        check("rst_a_idx", 32'(a_if.tt_idx), 32'd0);
        check("rst_a_data", 32'(a_if.tt_data), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        check("rst_b_valid", 32'(b_if.tt_valid), 32'd0);
        rst_n = 1'b1;

        run_a(0);
        run_a(1);

        // Abort a sweep with a two-clock reset.
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_x", 32'(a_x), 32'd0);
        check("abort_valid", 32'(a_if.tt_valid), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        rst_n = 1'b1;
        run_a(0);

        repeat (5) run_a(2);
        repeat (4) run_b();

        @(posedge clk); #1;
        check("a_done_count", 32'(a_done_cnt), 32'(a_done_exp));
        check("b_done_count", 32'(b_done_cnt), 32'(b_done_exp));
        check("a_queue_drained", 32'(a_qi.size()), 32'd0);
        check("b_queue_drained", 32'(b_qi.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
